// File: rtl/match_controller_pkg.sv
// Shared types and constants for the tic-tac-toe match controller.
package match_controller_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PLAY,
    CHECK,
    ROUND_END,
    MATCH_OVER
  } state_e;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P0   = 2'b01;
  localparam logic [1:0] WIN_P1   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  localparam logic [3:0] MAX_MOVES = 4'd9;

  // One-hot per-player code used for acks and the match winner.
  function automatic logic [1:0] player_code(input logic p);
    return p ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/match_controller_cycle_timer.sv
// Down-counting wait timer: load on start, done while the count sits at terminal value 1.
module match_controller_cycle_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == W'(1));

endmodule

// File: rtl/match_controller.sv
// Tic-tac-toe match sequencer: turn arbitration, win sampling, scores, round/match control.
//   state      | meaning
//   IDLE       | after reset, waiting for start
//   PLAY       | waiting for the turn player's move request
//   CHECK      | waiting for the checker, then sampling win_signal once
//   ROUND_END  | holding the round result before clearing the board
//   MATCH_OVER | winner declared, everything frozen until start
module match_controller
  import match_controller_pkg::*;
#(
  parameter int WIN_TARGET  = 3,
  parameter int SCORE_W     = 5,
  parameter int CHECK_LAT   = 2,
  parameter int HOLD_CYCLES = 16
) (
  input  logic               clk,
  input  logic               globalReset_n,
  input  logic               start,
  input  logic [1:0]         move_req,
  input  logic [1:0]         win_signal,
  output logic [1:0]         move_ack,
  output logic               turn,
  output logic               board_clear,
  output logic [SCORE_W-1:0] score0,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] draws,
  output logic               match_over,
  output logic [1:0]         match_winner
);

  localparam int TMR_MAX = ((CHECK_LAT + 1) > HOLD_CYCLES) ? (CHECK_LAT + 1) : HOLD_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [SCORE_W-1:0] WIN_TGT   = SCORE_W'(WIN_TARGET);

  state_e             state_q, state_d;
  logic               turn_q, turn_d;
  logic               first_q, first_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [SCORE_W-1:0] score0_q, score0_d;
  logic [SCORE_W-1:0] score1_q, score1_d;
  logic [SCORE_W-1:0] draws_q, draws_d;
  logic [1:0]         ack_q, ack_d;
  logic               clear_q, clear_d;
  logic               over_q, over_d;
  logic [1:0]         winner_q, winner_d;

  logic               tmr_start;
  logic [TMR_W-1:0]   tmr_load;
  logic               tmr_done;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == SCORE_MAX) ? v : v + 1'b1;
  endfunction

  match_controller_cycle_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst_n    (globalReset_n),
    .start    (tmr_start),
    .load_val (tmr_load),
    .done     (tmr_done)
  );

  always_comb begin
    state_d   = state_q;
    turn_d    = turn_q;
    first_d   = first_q;
    cnt_d     = cnt_q;
    score0_d  = score0_q;
    score1_d  = score1_q;
    draws_d   = draws_q;
    over_d    = over_q;
    winner_d  = winner_q;
    ack_d     = 2'b00;
    clear_d   = 1'b0;
    tmr_start = 1'b0;
    tmr_load  = '0;

    unique case (state_q)
      IDLE, MATCH_OVER: begin
        if (start) begin
          clear_d  = 1'b1;
          score0_d = '0;
          score1_d = '0;
          draws_d  = '0;
          cnt_d    = '0;
          first_d  = 1'b0;
          turn_d   = 1'b0;
          over_d   = 1'b0;
          winner_d = 2'b00;
          state_d  = PLAY;
        end
      end
      PLAY: begin
        if (move_req[turn_q]) begin
          ack_d     = player_code(turn_q);
          cnt_d     = cnt_q + 4'd1;
          tmr_start = 1'b1;
          tmr_load  = TMR_W'(CHECK_LAT + 1);
          state_d   = CHECK;
        end
      end
      CHECK: begin
        if (tmr_done) begin
          tmr_load = TMR_W'(HOLD_CYCLES);
          unique case (win_signal)
            WIN_P0:   score0_d = sat_inc(score0_q);
            WIN_P1:   score1_d = sat_inc(score1_q);
            WIN_DRAW: draws_d  = sat_inc(draws_q);
            default: begin
              if (cnt_q >= MAX_MOVES) begin
                draws_d = sat_inc(draws_q);
              end
            end
          endcase
          if (win_signal == WIN_NONE && cnt_q < MAX_MOVES) begin
            turn_d  = ~turn_q;
            state_d = PLAY;
          end else begin
            tmr_start = 1'b1;
            state_d   = ROUND_END;
          end
        end
      end
      ROUND_END: begin
        if (tmr_done) begin
          if (score0_q == WIN_TGT || score1_q == WIN_TGT) begin
            over_d   = 1'b1;
            winner_d = player_code(score1_q == WIN_TGT);
            state_d  = MATCH_OVER;
          end else begin
            clear_d = 1'b1;
            cnt_d   = '0;
            first_d = ~first_q;
            turn_d  = ~first_q;
            state_d = PLAY;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge globalReset_n) begin
    if (!globalReset_n) begin
      state_q  <= IDLE;
      turn_q   <= 1'b0;
      first_q  <= 1'b0;
      cnt_q    <= '0;
      score0_q <= '0;
      score1_q <= '0;
      draws_q  <= '0;
      ack_q    <= 2'b00;
      clear_q  <= 1'b0;
      over_q   <= 1'b0;
      winner_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      turn_q   <= turn_d;
      first_q  <= first_d;
      cnt_q    <= cnt_d;
      score0_q <= score0_d;
      score1_q <= score1_d;
      draws_q  <= draws_d;
      ack_q    <= ack_d;
      clear_q  <= clear_d;
      over_q   <= over_d;
      winner_q <= winner_d;
    end
  end

  assign move_ack     = ack_q;
  assign turn         = turn_q;
  assign board_clear  = clear_q;
  assign score0       = score0_q;
  assign score1       = score1_q;
  assign draws        = draws_q;
  assign match_over   = over_q;
  assign match_winner = winner_q;

endmodule

// File: tb/tb_match_controller.sv
// Randomized self-checking bench for match_controller against a move-level match model.
module tb_match_controller;

  localparam int WIN_TARGET  = 3;
  localparam int SCORE_W     = 5;
  localparam int CHECK_LAT   = 2;
  localparam int HOLD_CYCLES = 16;
  localparam int SCORE_SAT   = (1 << SCORE_W) - 1;

  logic               clk = 1'b0;
  logic               globalReset_n = 1'b0;
  logic               start = 1'b0;
  logic [1:0]         move_req = 2'b00;
  logic [1:0]         win_signal = 2'b00;
  logic [1:0]         move_ack;
  logic               turn;
  logic               board_clear;
  logic [SCORE_W-1:0] score0;
  logic [SCORE_W-1:0] score1;
  logic [SCORE_W-1:0] draws;
  logic               match_over;
  logic [1:0]         match_winner;

  int total = 0;
  int bad   = 0;

  // match model: scores, whose turn, who opened the round, marks placed, result
  int       m_s0, m_s1, m_dr, m_cnt;
  bit       m_turn, m_first, m_over;
  logic [1:0] m_win;

  match_controller #(
    .WIN_TARGET  (WIN_TARGET),
    .SCORE_W     (SCORE_W),
    .CHECK_LAT   (CHECK_LAT),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) dut (
    .clk          (clk),
    .globalReset_n(globalReset_n),
    .start        (start),
    .move_req     (move_req),
    .win_signal   (win_signal),
    .move_ack     (move_ack),
    .turn         (turn),
    .board_clear  (board_clear),
    .score0       (score0),
    .score1       (score1),
    .draws        (draws),
    .match_over   (match_over),
    .match_winner (match_winner)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: run did not finish (got=timeout exp=finish)");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] pcode(input bit p);
    return p ? 2'b10 : 2'b01;
  endfunction

  function automatic int sat(input int v);
    return (v + 1 > SCORE_SAT) ? SCORE_SAT : v + 1;
  endfunction

  function automatic logic [1:0] rand_ws();
    int r;
    r = $urandom_range(0, 9);
    if (r < 2) return 2'b01;
    if (r < 4) return 2'b10;
    if (r == 4) return 2'b11;
    return 2'b00;
  endfunction

  task automatic model_clear();
    m_s0 = 0; m_s1 = 0; m_dr = 0; m_cnt = 0;
    m_turn = 0; m_first = 0; m_over = 0; m_win = 2'b00;
  endtask

  task automatic check_outputs(input string where);
    check_eq({where, ":score0"}, 32'(score0), 32'(m_s0));
    check_eq({where, ":score1"}, 32'(score1), 32'(m_s1));
    check_eq({where, ":draws"}, 32'(draws), 32'(m_dr));
    check_eq({where, ":turn"}, 32'(turn), 32'(m_turn));
    check_eq({where, ":match_over"}, 32'(match_over), 32'(m_over));
    check_eq({where, ":match_winner"}, 32'(match_winner), 32'(m_win));
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    model_clear();
    check_eq("start:board_clear", 32'(board_clear), 32'd1);
    check_outputs("start");
  endtask

  task automatic do_move(input logic [1:0] ws, input bit both);
    bit ended;
    if (!both && $urandom_range(0, 2) == 0) begin
      move_req = pcode(!m_turn);
      repeat ($urandom_range(1, 3)) begin
        tick();
        check_eq("wrong_player_ack", 32'(move_ack), 32'd0);
      end
    end
    move_req = (both || $urandom_range(0, 1) == 1) ? 2'b11 : pcode(m_turn);
    tick();
    check_eq("move_ack", 32'(move_ack), 32'(pcode(m_turn)));
    check_eq("board_clear_in_play", 32'(board_clear), 32'd0);
    win_signal = ws;
    move_req = 2'($urandom_range(0, 3));
    for (int i = 0; i < CHECK_LAT + 1; i++) begin
      tick();
      check_eq("ack_in_check", 32'(move_ack), 32'd0);
    end
    move_req = 2'b00;
    win_signal = 2'($urandom_range(0, 3));

    m_cnt++;
    ended = 1'b1;
    case (ws)
      2'b01:   m_s0 = sat(m_s0);
      2'b10:   m_s1 = sat(m_s1);
      2'b11:   m_dr = sat(m_dr);
      default: begin
        if (m_cnt >= 9) m_dr = sat(m_dr);
        else begin
          ended  = 1'b0;
          m_turn = !m_turn;
        end
      end
    endcase
    check_outputs("after_sample");

    if (ended) begin
      for (int i = 0; i < HOLD_CYCLES - 1; i++) begin
        move_req = 2'($urandom_range(0, 3));
        tick();
        check_eq("clear_early", 32'(board_clear), 32'd0);
        check_eq("ack_in_hold", 32'(move_ack), 32'd0);
      end
      move_req = 2'($urandom_range(0, 3));
      tick();
      move_req = 2'b00;
      if (m_s0 == WIN_TARGET || m_s1 == WIN_TARGET) begin
        m_over = 1'b1;
        m_win  = pcode(m_s1 == WIN_TARGET);
      end else begin
        m_first = !m_first;
        m_turn  = m_first;
        m_cnt   = 0;
      end
      check_eq("board_clear_end", 32'(board_clear), 32'(!m_over));
      check_outputs("round_end");
    end
  endtask

  task automatic over_idle(input int n);
    for (int i = 0; i < n; i++) begin
      move_req   = 2'($urandom_range(0, 3));
      win_signal = 2'($urandom_range(0, 3));
      tick();
      check_eq("frozen_ack", 32'(move_ack), 32'd0);
      check_eq("frozen_clear", 32'(board_clear), 32'd0);
      check_outputs("frozen");
    end
    move_req = 2'b00;
  endtask

  initial begin
    int guard;
    model_clear();
    #1;
    check_eq("reset:move_ack", 32'(move_ack), 32'd0);
    check_eq("reset:board_clear", 32'(board_clear), 32'd0);
    check_outputs("reset");
    repeat (2) tick();
    globalReset_n = 1'b1;

    move_req = 2'b11;
    repeat (3) begin
      tick();
      check_eq("idle_ack", 32'(move_ack), 32'd0);
    end
    move_req = 2'b00;

    do_start();
    move_req = 2'b10;
    repeat (2) begin
      tick();
      check_eq("p1_req_turn0", 32'(move_ack), 32'd0);
    end
    move_req = 2'b00;
    do_move(2'b01, 1'b0);
    do_move(2'b01, 1'b1);

    // reset while the checker wait is in progress
    move_req = pcode(m_turn);
    tick();
    check_eq("pre_reset_ack", 32'(move_ack), 32'(pcode(m_turn)));
    move_req = 2'b00;
    tick();
    globalReset_n = 1'b0;
    #1;
    model_clear();
    check_eq("rst_mid:move_ack", 32'(move_ack), 32'd0);
    check_eq("rst_mid:board_clear", 32'(board_clear), 32'd0);
    check_outputs("rst_mid");
    tick();
    globalReset_n = 1'b1;
    move_req = 2'b11;
    repeat (2) begin
      tick();
      check_eq("post_reset_idle_ack", 32'(move_ack), 32'd0);
    end
    move_req = 2'b00;

    do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("start_in_play", 32'(board_clear), 32'd0);
    check_outputs("start_in_play");
    repeat (9) do_move(2'b00, 1'($urandom_range(0, 1)));
    repeat (4) do_move(2'b00, 1'($urandom_range(0, 1)));
    do_move(2'b11, 1'b0);
    check_eq("draws_two", 32'(draws), 32'd2);

    repeat (3) do_move(2'b10, 1'($urandom_range(0, 1)));
    check_eq("p1_match_over", 32'(match_over), 32'd1);
    check_eq("p1_match_winner", 32'(match_winner), 32'd2);
    over_idle(20);
    do_start();

    for (int m = 0; m < 3; m++) begin
      guard = 0;
      while (!m_over && guard < 300) begin
        do_move(rand_ws(), $urandom_range(0, 3) == 0);
        guard++;
      end
      over_idle(5);
      do_start();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
